// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID fetch queue pairing SRAM read data with the PC of its fetch
// Ports: cpu_clk_50M clock, cpu_rst_n async active-low reset; ice/if_pc/if_pc_plus_4 fetch
// issued this cycle; inst_rdata SRAM data valid the cycle after ice; stall[2] decode not
// accepting; flush drops queued and in-flight work; id_valid/id_pc/id_pc_plus_4/id_inst head
// entry to decode; fetch_stall_req asks fetch to hold the PC; ifq_overflow sticky flag set by a
// push into a full queue. Define IFQ_BYPASS_EN to hand an arriving instruction straight to decode
// when the queue is empty.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef INST_BUS
`define INST_BUS 31:0
`endif
`ifndef STALL_BUS
`define STALL_BUS 3:0
`endif
`ifndef PC_INIT
`define PC_INIT 32'h00000000
`endif
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  ice,
  input  logic [`INST_ADDR_BUS] if_pc,
  input  logic [`INST_ADDR_BUS] if_pc_plus_4,
  input  logic [`INST_BUS]      inst_rdata,
  input  logic [`STALL_BUS]     stall,
  input  logic                  flush,
  output logic                  id_valid,
  output logic [`INST_ADDR_BUS] id_pc,
  output logic [`INST_ADDR_BUS] id_pc_plus_4,
  output logic [`INST_BUS]      id_inst,
  output logic                  fetch_stall_req,
  output logic                  ifq_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic                  infl_v;
  logic [`INST_ADDR_BUS] infl_pc, infl_pc4;
  logic [`INST_ADDR_BUS] mem_pc [DEPTH];
  logic [`INST_ADDR_BUS] mem_pc4 [DEPTH];
  logic [`INST_BUS]      mem_inst [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [AW:0]           count;
  logic                  empty, full, do_push, do_pop, wr_en;
  logic                  unused_stall;
  assign unused_stall = ^stall;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp = empty & infl_v;
  assign id_valid = ~empty | infl_v;
  assign id_pc = byp ? infl_pc : empty ? `PC_INIT : mem_pc[rd_ptr];
  assign id_pc_plus_4 = byp ? infl_pc4 : empty ? `PC_INIT : mem_pc4[rd_ptr];
  assign id_inst = byp ? inst_rdata : empty ? '0 : mem_inst[rd_ptr];
  // a bypassed entry taken by decode this cycle never enters storage
  assign do_push = infl_v & ~(byp & ~stall[2]);
`else
  assign id_valid = ~empty;
  assign id_pc = empty ? `PC_INIT : mem_pc[rd_ptr];
  assign id_pc_plus_4 = empty ? `PC_INIT : mem_pc4[rd_ptr];
  assign id_inst = empty ? '0 : mem_inst[rd_ptr];
  assign do_push = infl_v;
`endif
  assign do_pop = ~empty & ~stall[2];
  // a pop frees the head slot first, so a full queue still accepts a push alongside it
  assign wr_en = do_push & (~full | do_pop);
  // counts the in-flight fetch but ignores a pending pop, so it errs on stalling early
  assign fetch_stall_req = ({1'b0, count} + (AW+2)'(infl_v)) >= (AW+2)'(DEPTH);
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n)
    if (!cpu_rst_n) begin
      infl_v <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ifq_overflow <= 1'b0;
    end else if (flush) begin
      infl_v <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      infl_v <= ice;
      rd_ptr <= rd_ptr + AW'(do_pop);
      wr_ptr <= wr_ptr + AW'(wr_en);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(do_pop);
      if (do_push & full & ~do_pop) ifq_overflow <= 1'b1;
    end
  always_ff @(posedge cpu_clk_50M) begin
    infl_pc <= if_pc;
    infl_pc4 <= if_pc_plus_4;
    if (wr_en & ~flush) begin
      mem_pc[wr_ptr] <= infl_pc;
      mem_pc4[wr_ptr] <= infl_pc4;
      mem_inst[wr_ptr] <= inst_rdata;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue with DEPTH=4, bypass disabled
module tb_if_id_queue;
  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        ice = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_pc_plus_4 = '0;
  logic [31:0] inst_rdata = '0;
  logic [3:0]  stall = '0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus_4, id_inst;
  logic        fetch_stall_req, ifq_overflow;
  logic        sram_v;
  logic [31:0] sram_a;
  int          n_assert = 0;
  int          n_fail = 0;
  if_id_queue #(.DEPTH(4)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .ice(ice), .if_pc(if_pc),
    .if_pc_plus_4(if_pc_plus_4), .inst_rdata(inst_rdata), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4), .id_inst(id_inst),
    .fetch_stall_req(fetch_stall_req), .ifq_overflow(ifq_overflow)
  );
  always #5 cpu_clk_50M = ~cpu_clk_50M;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, id_valid}, {31'b0, v});
    chk({tag, "_pc"}, id_pc, v ? pc : 32'h0);
    chk({tag, "_pc4"}, id_pc_plus_4, v ? pc + 32'd4 : 32'h0);
    chk({tag, "_inst"}, id_inst, v ? (pc | 32'hA000_0000) : 32'h0);
  endtask
  task automatic flags(input string tag, input logic fsr, input logic ovf);
    chk({tag, "_fsr"}, {31'b0, fetch_stall_req}, {31'b0, fsr});
    chk({tag, "_ovf"}, {31'b0, ifq_overflow}, {31'b0, ovf});
  endtask
  // one clock: the SRAM answers the fetch sampled at this edge with PC|0xA0000000
  task automatic tick();
    @(posedge cpu_clk_50M);
    sram_v = ice;
    sram_a = if_pc;
    #1;
    inst_rdata = sram_v ? (sram_a | 32'hA000_0000) : 32'h0;
  endtask
  task automatic fetch(input logic i, input logic [31:0] pc);
    ice = i;
    if_pc = pc;
    if_pc_plus_4 = pc + 32'd4;
    tick();
  endtask
  initial begin
    #3;
    head("rst", 1'b0, 32'h0);
    flags("rst", 1'b0, 1'b0);
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;
    tick();
    // streaming: one instruction per cycle, first visible two cycles after its fetch
    for (int k = 1; k <= 8; k++) begin
      fetch(k <= 6, 32'(4 * (k - 1)));
      if (k >= 2 && k <= 7) head($sformatf("stream%0d", k), 1'b1, 32'(4 * (k - 2)));
      else head($sformatf("stream%0d", k), 1'b0, 32'h0);
      chk($sformatf("stream%0d_fsr", k), {31'b0, fetch_stall_req}, 32'h0);
    end
    // back-pressure: fetch honours fetch_stall_req while decode stalls
    stall = 4'b0100;
    fetch(1'b1, 32'h100); flags("bp1", 1'b0, 1'b0); head("bp1", 1'b0, 32'h0);
    fetch(1'b1, 32'h104); flags("bp2", 1'b0, 1'b0); head("bp2", 1'b1, 32'h100);
    fetch(1'b1, 32'h108); flags("bp3", 1'b0, 1'b0);
    fetch(1'b1, 32'h10c); flags("bp4", 1'b1, 1'b0);
    fetch(1'b0, 32'h110); flags("bp5", 1'b1, 1'b0);
    fetch(1'b0, 32'h110); flags("bp6", 1'b1, 1'b0); head("bp6", 1'b1, 32'h100);
    stall = 4'b0000;
    fetch(1'b0, 32'h110); flags("bp7", 1'b0, 1'b0); head("bp7", 1'b1, 32'h104);
    fetch(1'b0, 32'h110); head("bp8", 1'b1, 32'h108);
    fetch(1'b0, 32'h110); head("bp9", 1'b1, 32'h10c);
    fetch(1'b0, 32'h110); head("bp10", 1'b0, 32'h0);
    // full queue with simultaneous push and pop
    stall = 4'b0100;
    fetch(1'b1, 32'h200);
    fetch(1'b1, 32'h204);
    fetch(1'b1, 32'h208);
    fetch(1'b1, 32'h20c);
    fetch(1'b1, 32'h210); flags("pp5", 1'b1, 1'b0); head("pp5", 1'b1, 32'h200);
    stall = 4'b0000;
    fetch(1'b0, 32'h0); flags("pp6", 1'b1, 1'b0); head("pp6", 1'b1, 32'h204);
    fetch(1'b0, 32'h0); head("pp7", 1'b1, 32'h208);
    fetch(1'b0, 32'h0); head("pp8", 1'b1, 32'h20c);
    fetch(1'b0, 32'h0); head("pp9", 1'b1, 32'h210);
    fetch(1'b0, 32'h0); head("pp10", 1'b0, 32'h0); flags("pp10", 1'b0, 1'b0);
    // flush with two queued and one in flight, plus a fetch issued in the flush cycle
    stall = 4'b0100;
    fetch(1'b1, 32'h300);
    fetch(1'b1, 32'h304);
    fetch(1'b1, 32'h308); head("fl3", 1'b1, 32'h300);
    flush = 1'b1;
    fetch(1'b1, 32'h30c); head("fl4", 1'b0, 32'h0); flags("fl4", 1'b0, 1'b0);
    flush = 1'b0;
    stall = 4'b0000;
    fetch(1'b0, 32'h0); head("fl5", 1'b0, 32'h0);
    fetch(1'b0, 32'h0); head("fl6", 1'b0, 32'h0);
    // forced overflow ignoring fetch_stall_req
    stall = 4'b0100;
    fetch(1'b1, 32'h400);
    fetch(1'b1, 32'h404);
    fetch(1'b1, 32'h408);
    fetch(1'b1, 32'h40c);
    fetch(1'b1, 32'h410); flags("ov5", 1'b1, 1'b0);
    fetch(1'b1, 32'h414); flags("ov6", 1'b1, 1'b1);
    fetch(1'b0, 32'h0); flags("ov7", 1'b1, 1'b1); head("ov7", 1'b1, 32'h400);
    stall = 4'b0000;
    fetch(1'b0, 32'h0); head("ov8", 1'b1, 32'h404);
    fetch(1'b0, 32'h0); head("ov9", 1'b1, 32'h408);
    fetch(1'b0, 32'h0); head("ov10", 1'b1, 32'h40c);
    fetch(1'b0, 32'h0); head("ov11", 1'b0, 32'h0); flags("ov11", 1'b0, 1'b1);
    // asynchronous reset with three queued and one in flight
    stall = 4'b0100;
    fetch(1'b1, 32'h500);
    fetch(1'b1, 32'h504);
    fetch(1'b1, 32'h508);
    fetch(1'b1, 32'h50c); head("mr4", 1'b1, 32'h500); flags("mr4", 1'b1, 1'b1);
    ice = 1'b0;
    cpu_rst_n = 1'b0;
    #2;
    head("mrst", 1'b0, 32'h0);
    flags("mrst", 1'b0, 1'b0);
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1'b1;
    stall = 4'b0000;
    tick();
    head("post_rst", 1'b0, 32'h0);
    flags("post_rst", 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction fetch queue between the fetch stage and the decode stage of the MiniMIPS32 core. It captures each instruction returned by the synchronous instruction SRAM one cycle after the fetch was issued, pairs it with the PC and PC+4 of that fetch, and buffers the result in a small FIFO. Decode drains the FIFO in order. The queue also generates the back-pressure request that holds the PC, and drops all queued and in-flight work on an exception flush.

## Interface
- `DEPTH`, default 4: number of queue entries; must be a power of two, 2..16.
- `cpu_clk_50M` in 1: core clock; all state changes on the rising edge.
- `cpu_rst_n` in 1: asynchronous, active-low reset.
- `ice` in 1: fetch issued to the instruction SRAM this cycle.
- `if_pc` in `INST_ADDR_BUS`: PC of the fetch issued this cycle.
- `if_pc_plus_4` in `INST_ADDR_BUS`: PC+4 of the fetch issued this cycle.
- `inst_rdata` in `INST_BUS`: SRAM read data; valid the cycle after `ice`.
- `stall` in `STALL_BUS`: pipeline stall bus; `stall[2]`=1 means decode is not accepting.
- `flush` in 1: exception flush.
- `id_valid` out 1: queue head holds a valid instruction.
- `id_pc` out `INST_ADDR_BUS`: PC of the head entry.
- `id_pc_plus_4` out `INST_ADDR_BUS`: PC+4 of the head entry.
- `id_inst` out `INST_BUS`: instruction word of the head entry.
- `fetch_stall_req` out 1: request that fetch hold the PC and deassert `ice`.
- `ifq_overflow` out 1: sticky error flag, set when a push arrives while the queue is full.

## Operation
- **In-flight tracking.**
  - The in-flight register (`infl_v`, `infl_pc`, `infl_pc4`) loads `ice`, `if_pc` and `if_pc_plus_4` every cycle.
  - Next cycle, `push = infl_v`; the entry written is {`infl_pc`, `infl_pc4`, `inst_rdata`}.
- **Storage.**
  - Circular buffer with `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits, range 0..DEPTH.
- **Pop.** `pop = id_valid & ~stall[2]`.
- **Push and pop in the same cycle.**
  - Both pointers advance and `count` is unchanged.
  - Allowed even when full, because the pop frees a slot first.
- **Overflow.**
  - Push while `count==DEPTH` with no pop: the push is dropped.
  - `ifq_overflow` sets to 1 and stays at 1 until reset.
- **Head outputs.**
  - Driven combinationally from the entry at `rd_ptr`.
  - When `count==0`: `id_valid`=0, `id_inst`=0x00000000 (NOP), `id_pc`=`PC_INIT`, `id_pc_plus_4`=`PC_INIT`.
- **Back-pressure.**
  - `fetch_stall_req = (count + infl_v) >= DEPTH`, combinational from registers only.
  - Pop is ignored here; the term is deliberately conservative.
- **Flush** has priority over push and pop:
  - `count`, `rd_ptr`, `wr_ptr` and `infl_v` clear to 0.
  - Data arriving on `inst_rdata` in the flush cycle is discarded.
  - Any `ice` issued in the flush cycle is not recorded.
- **Reset**, asynchronous and valid at any point including mid-operation:
  - `count`, pointers, `infl_v` and `ifq_overflow` go to 0.
  - Outputs then show the empty values and `fetch_stall_req`=0.
  - Storage contents are not reset.

## Timing
- Latency without bypass: `ice` in cycle N → SRAM data in cycle N+1 → pushed at the end of N+1 → `id_valid` visible in N+2.
- Throughput: one instruction per cycle when fetch issues continuously and `stall[2]`=0.
- `fetch_stall_req` with DEPTH=4:
  - Rises in the cycle where `count+infl_v` reaches 4.
  - Falls the cycle after the first pop that brings the sum below 4.
- Decode must sample the `id_*` outputs on the same edge at which `pop` is taken.

## Configuration
- Macro `IFQ_BYPASS_EN`.
- **Defined:**
  - When `count==0` and `push`=1, the head outputs present {`infl_pc`, `infl_pc4`, `inst_rdata`} directly, with `id_valid`=1 in cycle N+1.
  - If `stall[2]`=0 in that cycle, the entry is consumed without being written; pointers and `count` are unchanged.
  - If `stall[2]`=1, the entry is written normally.
  - `fetch_stall_req` is unchanged from the non-bypass definition.
- **Undefined:** no bypass; the minimum latency is N+2 as listed under Timing.

## Test plan
- **Reset mid-stream.** Assert `cpu_rst_n`=0 while `count`=3 → same cycle: `id_valid`=0, `id_inst`=0, `fetch_stall_req`=0, `ifq_overflow`=0.
- **Streaming.** `ice`=1 for 6 cycles, PCs 0x00000000..0x00000014, `inst_rdata` = PC|0xA0000000, `stall[2]`=0 → `id_pc` sequence 0x0..0x14, in order, starting N+2 (N+1 with `IFQ_BYPASS_EN`), no gaps.
- **Back-pressure and wrap.**
  - `stall[2]`=1 with DEPTH=4 and continuous fetch → `fetch_stall_req`=1 once `count+infl_v`=4, and `count` saturates at 4.
  - Release `stall[2]` → 4 pops in order; pointers wrap 3→0 with no lost or duplicated entries.
- **Simultaneous push/pop when full.** `count`=4, `push`=1, `pop`=1 → `count` stays 4, the head advances, and the new entry lands at the old `rd_ptr` slot; `ifq_overflow` stays 0.
- **Flush with in-flight fetch.** `count`=2, `infl_v`=1, assert `flush` → next cycle `count`=0 and `id_valid`=0; the in-flight instruction never appears on `id_*`.
- **Forced overflow.** Ignore `fetch_stall_req` and hold `ice`=1 with `stall[2]`=1 → the fifth push is dropped, `ifq_overflow`=1 and stays 1, and the first four entries are intact.
